logarithm: RTL and testbench

//  Fixed-point natural-log accelerator: the inverse of the exponential unit. It accepts a 2.16

---
 rtl/logarithm_pkg.sv | 35 +++
 rtl/logarithm_ln_datapath.sv | 60 ++++++
 rtl/logarithm.sv | 91 +++++++++
 tb/tb_logarithm.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/logarithm_pkg.sv
// Shared constants for the fixed-point natural-log unit: widths, FSM encoding and
// the ln(1+2^-k) table used by the multiplicative-normalisation datapath.
package logarithm_pkg;
   localparam int FRAC_W = 16;
   localparam int GUARD  = 4;
   localparam int N_ITER = FRAC_W + 1;
   localparam int IW     = FRAC_W + GUARD;
   localparam int K_W    = $clog2(N_ITER);

   typedef enum logic [1:0] {IDLE, LOAD, ITER, FIN} state_e;

   // round(ln(1+2^-k) * 2^(FRAC_W+GUARD)); from k=11 on this is exactly 2^(IW-k)
   function automatic logic [IW:0] lntab(input logic [K_W-1:0] k);
      case (k)
         5'd0:    return 21'd726817;
         5'd1:    return 21'd425161;
         5'd2:    return 21'd233983;
         5'd3:    return 21'd123504;
         5'd4:    return 21'd63570;
         5'd5:    return 21'd32266;
         5'd6:    return 21'd16257;
         5'd7:    return 21'd8160;
         5'd8:    return 21'd4088;
         5'd9:    return 21'd2046;
         5'd10:   return 21'd1024;
         5'd11:   return 21'd512;
         5'd12:   return 21'd256;
         5'd13:   return 21'd128;
         5'd14:   return 21'd64;
         5'd15:   return 21'd32;
         5'd16:   return 21'd16;
         default: return 21'd0;
      endcase
   endfunction
endpackage

// File: rtl/logarithm_ln_datapath.sv
// Datapath for ln(y): greedy product P climbs towards y by factors (1+2^-k) while
// R accumulates the matching ln terms; R is rounded to FRAC_W bits on the way out.
module ln_datapath
   import logarithm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              iter,
   input  logic [K_W-1:0]    k,
   input  logic [FRAC_W+1:0] y,
   output logic [FRAC_W:0]   r_rnd,
   output logic              y_lt_one
);
   localparam logic [IW+1:0]   P_ONE = {2'b01, {IW{1'b0}}};
   localparam logic [FRAC_W+1:0] Y_ONE = {2'b01, {FRAC_W{1'b0}}};
   localparam logic [IW+1:0]   HALF  = (IW+2)'(1) << (GUARD - 1);

   logic [IW+1:0]     y_q, y_d, p_q, p_d;
   logic [IW:0]       r_q, r_d;
   logic              lt_q, lt_d;
   logic [IW+2:0]     t;
   logic [FRAC_W+1:0] r_sum;

   always_comb begin
      y_d  = y_q;
      p_d  = p_q;
      r_d  = r_q;
      lt_d = lt_q;
      // t can reach just under 8.0, hence the extra top bit
      t = {1'b0, p_q} + {1'b0, p_q >> k};
      if (load) begin
         y_d  = {y, {GUARD{1'b0}}};
         p_d  = P_ONE;
         r_d  = '0;
         lt_d = (y < Y_ONE);
      end else if (iter && (t <= {1'b0, y_q})) begin
         p_d = t[IW+1:0];
         r_d = r_q + lntab(k);
      end
      r_sum = (FRAC_W+2)'(({1'b0, r_q} + HALF) >> GUARD);
      r_rnd = r_sum[FRAC_W+1] ? '1 : r_sum[FRAC_W:0];
   end

   assign y_lt_one = lt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_q  <= '0;
         p_q  <= '0;
         r_q  <= '0;
         lt_q <= 1'b0;
      end else begin
         y_q  <= y_d;
         p_q  <= p_d;
         r_q  <= r_d;
         lt_q <= lt_d;
      end
   end
endmodule

// File: rtl/logarithm.sv
// Natural-log accelerator: start/done controller around ln_datapath. Fixed latency of
// N_ITER+2 cycles from the start-sampling edge to the done pulse.
module logarithm
   import logarithm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [FRAC_W+1:0] y,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [FRAC_W:0]   result
);
   state_e          state_q, state_d;
   logic [K_W-1:0]  k_q, k_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [FRAC_W:0] result_q, result_d, r_rnd;
   logic            load, iter, y_lt_one;

   ln_datapath u_dp (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .iter     (iter),
      .k        (k_q),
      .y        (y),
      .r_rnd    (r_rnd),
      .y_lt_one (y_lt_one)
   );

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      result_d = result_q;
      load     = 1'b0;
      iter     = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            busy_d  = 1'b1;
         end
         LOAD: begin
            load    = 1'b1;
            k_d     = '0;
            state_d = ITER;
         end
         ITER: begin
            iter = 1'b1;
            k_d  = k_q + 1'b1;
            if (k_q == K_W'(N_ITER - 1)) begin
               state_d = FIN;
               busy_d  = 1'b0;
            end
         end
         FIN: begin
            done_d   = 1'b1;
            err_d    = y_lt_one;
            result_d = y_lt_one ? '0 : r_rnd;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;
endmodule

// File: tb/tb_logarithm.sv
// Scoreboard bench for logarithm: stimulus pushes expected ln values, a negedge
// monitor pops and checks result, err and latency on every done pulse.
module tb_logarithm;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [17:0] y;
   logic        busy, done, err;
   logic [16:0] result;

   always #5 clk = ~clk;

   logarithm dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .y      (y),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result)
   );

   typedef struct {
      real   exp_v;
      real   tol;
      logic  exp_err;
      int    due;
      string name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, errors = 0;
   int   cyc = 0, done_cnt = 0, busy_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      real  diff;
      if (busy) busy_cnt++;
      if (rst && done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done result=%h", result);
         end else begin
            e = sb.pop_front();
            diff = $itor(result) - e.exp_v;
            if (diff < 0.0) diff = -diff;
            checks++;
            if (diff > e.tol) begin
               errors++;
               $display("FAIL %s result got=%h (%0d) want=%0.2f tol=%0.1f",
                        e.name, result, result, e.exp_v, e.tol);
            end
            checks++;
            if (err !== e.exp_err) begin
               errors++;
               $display("FAIL %s err got=%b want=%b", e.name, err, e.exp_err);
            end
            checks++;
            if (cyc != e.due) begin
               errors++;
               $display("FAIL %s latency done_at=%0d want=%0d", e.name, cyc, e.due);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   // rep>0 re-pulses start with y=1.0 that many cycles after the first start
   task automatic run_op(input logic [17:0] yv, input real ev, input real tol,
                         input logic ee, input string nm, input int rep);
      exp_t e;
      int   n0;
      @(negedge clk);
      y = yv; start = 1'b1;
      e.exp_v = ev; e.tol = tol; e.exp_err = ee; e.due = cyc + 20; e.name = nm;
      sb.push_back(e);
      n0 = done_cnt;
      for (int i = 1; i <= 40 && done_cnt == n0; i++) begin
         @(negedge clk);
         start = (rep != 0 && i == rep);
         if (i >= 2) y = start ? 18'h10000 : 18'h3FFFF;
      end
      start = 1'b0;
      if (done_cnt == n0) begin
         checks++; errors++;
         $display("FAIL %s timeout waiting for done", nm);
         void'(sb.pop_back());
      end
   endtask

   initial begin
      logic [17:0] yr;
      rst = 1'b0; start = 1'b0; y = '0;
      #12;
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      chk("rst_err",    {31'd0, err},  32'd0);
      chk("rst_result", {15'd0, result}, 32'd0);
      @(negedge clk); rst = 1'b1;

      @(posedge clk); busy_cnt = 0;
      run_op(18'h10000, 0.0, 0.0, 1'b0, "ln_1p0", 0);
      chk("busy_cycles", busy_cnt, 32'd18);
      run_op(18'h20000, 45426.0, 1.0, 1'b0, "ln_2p0", 0);
      run_op(18'h2B7E1, 65536.0, 2.0, 1'b0, "ln_e", 0);
      run_op(18'h38000, 82101.0, 2.0, 1'b0, "ln_3p5_repulse", 5);
      run_op(18'h0FFFF, 0.0, 0.0, 1'b1, "below_one_err", 0);
      run_op(18'h20000, 45426.0, 1.0, 1'b0, "err_cleared", 0);

      // abort mid-operation with async reset
      @(negedge clk); y = 18'h38000; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_busy",   {31'd0, busy}, 32'd0);
      chk("abort_done",   {31'd0, done}, 32'd0);
      chk("abort_err",    {31'd0, err},  32'd0);
      chk("abort_result", {15'd0, result}, 32'd0);
      @(negedge clk); rst = 1'b1;
      run_op(18'h20000, 45426.0, 1.0, 1'b0, "after_abort", 0);

      run_op(18'h3FFFF, $ln($itor(18'h3FFFF) / 65536.0) * 65536.0, 2.0, 1'b0, "max_y", 0);
      for (int n = 0; n < 1024; n++) begin
         yr = 18'($urandom_range(32'h3FFFF, 32'h10000));
         run_op(yr, $ln($itor(yr) / 65536.0) * 65536.0, 2.0, 1'b0, "rand", 0);
      end

      repeat (30) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
